// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command prefixes, mode bit positions, responder FSM states and segment codes
package tm1638_pkg;
    localparam logic [7:0] C_WRITE = 8'h40;
    localparam logic [7:0] C_READ  = 8'h42;
    localparam logic [7:0] C_ADDR  = 8'hC0;
    localparam logic [7:0] C_DISP  = 8'h80;
    localparam int B_READ  = 1;
    localparam int B_FIXED = 2;
    localparam int B_DISP  = 3;
    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, HOLD} state_t;
    localparam logic [7:0] S_0   = 8'h3F;
    localparam logic [7:0] S_1   = 8'h06;
    localparam logic [7:0] S_2   = 8'h5B;
    localparam logic [7:0] S_3   = 8'h4F;
    localparam logic [7:0] S_4   = 8'h66;
    localparam logic [7:0] S_5   = 8'h6D;
    localparam logic [7:0] S_6   = 8'h7D;
    localparam logic [7:0] S_7   = 8'h07;
    localparam logic [7:0] S_8   = 8'h7F;
    localparam logic [7:0] S_BLK = 8'h00;
endpackage

// File: rtl/tm1638_sync_edge.sv
// tm1638_sync_edge: multi-flop synchronizer with 1-clk rise/fall strobes on the synchronized level
module tm1638_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sr;
    logic prev;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], d};
            prev <= sr[SYNC_STAGES-1];
        end
    end
    assign q    = sr[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 device emulator (display RAM, display control, key-scan readback).
// Define TM1638_RESP_ERR_EN to build the saturating protocol error counter.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tm_cs,
    input  logic                   tm_clk,
    input  logic                   tm_dio_in,
    output logic                   tm_dio_out,
    output logic                   tm_dio_oe,
    input  logic [8*KEY_BYTES-1:0] keys,
    input  logic [3:0]             ram_raddr,
    output logic [7:0]             ram_rdata,
    output logic                   display_on,
    output logic [2:0]             brightness,
    output logic                   wr_done,
    output logic [7:0]             err_cnt
);
    logic cs_s, cs_rise, cs_fall, clk_s, clk_rise, clk_fall, dio_s;
    logic [SYNC_STAGES-1:0] dio_sr;
    state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic byte_rdy, fixed_addr, wrote;
    logic [3:0] addr;
    logic [7:0] ram [16];
    logic [8*KEY_BYTES-1:0] snap;

    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(tm_cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
        .clk(clk), .rst_n(rst_n), .d(tm_clk), .q(clk_s), .rise(clk_rise), .fall(clk_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) dio_sr <= '1;
        else dio_sr <= {dio_sr[SYNC_STAGES-2:0], tm_dio_in};
    end
    assign dio_s = dio_sr[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_rdy   <= 1'b0;
            fixed_addr <= 1'b0;
            addr       <= '0;
            wrote      <= 1'b0;
            snap       <= '0;
            display_on <= 1'b0;
            brightness <= '0;
            wr_done    <= 1'b0;
            tm_dio_oe  <= 1'b0;
            tm_dio_out <= 1'b1;
            ram_rdata  <= '0;
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            byte_rdy  <= 1'b0;
            wr_done   <= 1'b0;
            ram_rdata <= ram[ram_raddr];
            if (cs_rise) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                tm_dio_oe  <= 1'b0;
                tm_dio_out <= 1'b1;
                wr_done    <= wrote;
                wrote      <= 1'b0;
            end else if (cs_fall) begin
                state   <= CMD;
                bit_cnt <= '0;
                wrote   <= 1'b0;
            end else begin
                if (clk_rise && !cs_s && state != IDLE && state != RDATA) begin
                    shreg    <= {dio_s, shreg[7:1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                    byte_rdy <= bit_cnt == 3'd7;
                end
                if (byte_rdy) begin
                    case (state)
                        CMD: begin
                            if (shreg[7:6] == C_WRITE[7:6]) begin
                                fixed_addr <= shreg[B_FIXED];
                                if (shreg[B_READ]) begin
                                    state     <= RDATA;
                                    snap      <= keys;
                                    tm_dio_oe <= 1'b1;
                                end else state <= HOLD;
                            end else if (shreg[7:6] == C_ADDR[7:6]) begin
                                addr  <= shreg[3:0];
                                state <= WDATA;
                            end else if (shreg[7:6] == C_DISP[7:6]) begin
                                display_on <= shreg[B_DISP];
                                brightness <= shreg[2:0];
                                state      <= HOLD;
                            end else state <= HOLD;
                        end
                        WDATA: begin
                            ram[addr] <= shreg;
                            addr      <= fixed_addr ? addr : addr + 4'd1;
                            wrote     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Zeros shift in behind the snapshot, so DIO idles low once all key bits are out
                if (state == RDATA && clk_fall) begin
                    tm_dio_out <= snap[0];
                    snap       <= snap >> 1;
                end
            end
        end
    end

`ifdef TM1638_RESP_ERR_EN
    logic err_ev;
    assign err_ev = cs_rise ? bit_cnt != 3'd0
                  : byte_rdy && (state == HOLD || (state == CMD && shreg[7:6] == 2'b00));
    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt <= '0;
        else if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: randomized TM1638 transactions checked against a byte-level device model
module tb_tm1638_responder;
    localparam int KB = 4;
    logic clk = 1'b0, rst_n = 1'b0, tm_cs = 1'b1, tm_clk = 1'b1, tm_dio_in = 1'b1;
    logic tm_dio_out, tm_dio_oe, display_on, wr_done;
    logic [8*KB-1:0] keys = '0;
    logic [3:0] ram_raddr = '0;
    logic [7:0] ram_rdata, err_cnt;
    logic [2:0] brightness;
    int checks = 0, errors = 0, wr_pulses = 0;
    logic [7:0] m_ram [16];
    logic [7:0] wq [$];
    int m_addr = 0, m_bright = 0, m_err = 0;
    bit m_fixed = 0, m_on = 0;

    tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(KB)) dut (
        .clk(clk), .rst_n(rst_n), .tm_cs(tm_cs), .tm_clk(tm_clk), .tm_dio_in(tm_dio_in),
        .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe), .keys(keys),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .display_on(display_on),
        .brightness(brightness), .wr_done(wr_done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (wr_done) wr_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_err();
`ifdef TM1638_RESP_ERR_EN
        return m_err > 255 ? 255 : m_err;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        tm_clk = 1'b0; tm_dio_in = b; tick(4);
        tm_clk = 1'b1; tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic cs_lo;
        tm_cs = 1'b0; tick(4);
    endtask

    task automatic cs_hi;
        tick(2); tm_cs = 1'b1; tick(8);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        ram_raddr = a; tick(1); d = ram_rdata;
    endtask

    task automatic check_state;
        logic [7:0] d;
        check("display_on", display_on, m_on);
        check("brightness", brightness, m_bright);
        check("err_cnt", err_cnt, exp_err());
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d);
            check($sformatf("ram[%0d]", i), d, m_ram[i]);
        end
    endtask

    // single-byte command (data-write, display or unknown) followed by extra ignored bytes
    task automatic t_cmd(input logic [7:0] b, input int extra);
        int w0 = wr_pulses;
        cs_lo; send_byte(b);
        for (int i = 0; i < extra; i++) send_byte(8'($urandom));
        cs_hi;
        if (b[7:6] == 2'b01) m_fixed = b[2];
        else if (b[7:6] == 2'b10) begin m_on = b[3]; m_bright = int'(b[2:0]); end
        else m_err++;
        m_err += extra;
        check("wr_done_cmd", wr_pulses - w0, 0);
    endtask

    task automatic t_write(input logic [3:0] a);
        int w0 = wr_pulses;
        cs_lo; send_byte({4'hC, a});
        foreach (wq[i]) send_byte(wq[i]);
        cs_hi;
        m_addr = a;
        foreach (wq[i]) begin
            m_ram[m_addr] = wq[i];
            if (!m_fixed) m_addr = (m_addr + 1) % 16;
        end
        check("wr_done_write", wr_pulses - w0, wq.size() > 0 ? 1 : 0);
    endtask

    task automatic t_read(input logic [8*KB-1:0] k, input logic fixed, output logic [8*KB-1:0] rx);
        int w0 = wr_pulses;
        keys = k;
        cs_lo; send_byte({5'b01000, fixed, 2'b10});
        for (int i = 0; i < 8 * KB; i++) begin
            tm_clk = 1'b0; tick(4);
            rx[i] = tm_dio_out;
            tm_clk = 1'b1; tick(4);
        end
        tm_clk = 1'b0; tick(4);
        check("dio_after_keys", tm_dio_out, 0);
        check("dio_oe_read", tm_dio_oe, 1);
        tm_clk = 1'b1; tick(4);
        tm_cs = 1'b1; tick(3);
        check("dio_oe_release", tm_dio_oe, 0);
        check("dio_out_release", tm_dio_out, 1);
        tick(5);
        m_fixed = fixed;
        check("keys", rx, k);
        check("wr_done_read", wr_pulses - w0, 0);
    endtask

    task automatic t_abort(input logic [3:0] a, input int nbits);
        int w0 = wr_pulses;
        cs_lo; send_byte({4'hC, a});
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
        cs_hi;
        m_addr = a;
        m_err++;
        check("wr_done_abort", wr_pulses - w0, 0);
    endtask

    initial begin
        logic [8*KB-1:0] rx;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        tick(4);
        check("rst_dio_oe", tm_dio_oe, 0);
        check("rst_dio_out", tm_dio_out, 1);
        check("rst_rdata", ram_rdata, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_disp", {display_on, brightness}, 0);
        rst_n = 1'b1; tick(4);

        t_cmd(8'h40, 0);
        wq = {8'h06, 8'h00, 8'h5B};
        for (int i = 3; i < 16; i++) wq.push_back(8'($urandom));
        t_write(4'h0);
        rd(4'h0, d); check("ram0_06", d, 8'h06);
        rd(4'h2, d); check("ram2_5b", d, 8'h5B);
        check_state;

        t_cmd(8'h40, 0);
        wq = {8'hAA, 8'hBB, 8'hCC};
        t_write(4'hE);
        rd(4'hE, d); check("wrap_e", d, 8'hAA);
        rd(4'hF, d); check("wrap_f", d, 8'hBB);
        rd(4'h0, d); check("wrap_0", d, 8'hCC);

        t_cmd(8'h44, 0);
        wq = {8'h11, 8'h22};
        t_write(4'h3);
        rd(4'h3, d); check("fixed_3", d, 8'h22);
        check_state;

        t_read(32'h10_01_00_11, 1'b0, rx);
        check("key_b0", rx[7:0], 8'h11);
        check("key_b1", rx[15:8], 8'h00);
        check("key_b2", rx[23:16], 8'h01);
        check("key_b3", rx[31:24], 8'h10);

        t_cmd(8'h8F, 0);
        check("disp_on_1", display_on, 1);
        check("bright_7", brightness, 7);
        t_cmd(8'h80, 0);
        check("disp_on_0", display_on, 0);
        check("bright_0", brightness, 0);

        t_abort(4'h0, 5);
        check_state;

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: t_cmd({2'b01, 4'($urandom), 1'b0, 1'($urandom)}, $urandom_range(0, 2));
                1: begin
                    wq = {};
                    for (int i = 0, c = $urandom_range(0, 5); i < c; i++) wq.push_back(8'($urandom));
                    t_write(4'($urandom));
                end
                2: t_cmd({2'b10, 6'($urandom)}, $urandom_range(0, 2));
                3: t_cmd({2'b00, 6'($urandom)}, $urandom_range(0, 1));
                4: t_read(32'($urandom), 1'($urandom), rx);
                default: t_abort(4'($urandom), $urandom_range(1, 7));
            endcase
            check_state;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
